// File: rtl/rom_arbiter_if.sv
// Bundle of both requester ports plus the ROM-side address/data of rom_arbiter.
// slave: the arbiter's view. master: the surrounding fetch/memory stages and the ROM.
// Requests are held until granted; responses are one-cycle pulses with no backpressure.
interface rom_arbiter_if #(
  parameter int AW = 10,
  parameter int DW = 32
);
  logic          req0;
  logic [AW-1:0] addr0;
  logic          gnt0;
  logic          rvalid0;
  logic [DW-1:0] rdata0;
  logic          req1;
  logic [AW-1:0] addr1;
  logic          gnt1;
  logic          rvalid1;
  logic [DW-1:0] rdata1;
  logic [AW-1:0] rom_addr;
  logic [DW-1:0] rom_dout;

  modport slave (
    input  req0, addr0, req1, addr1, rom_dout,
    output gnt0, rvalid0, rdata0, gnt1, rvalid1, rdata1, rom_addr
  );

  modport master (
    output req0, addr0, req1, addr1, rom_dout,
    input  gnt0, rvalid0, rdata0, gnt1, rvalid1, rdata1, rom_addr
  );
endinterface

// File: rtl/rom_arbiter.sv
// Shares one synchronous-read ROM between fetch (port 0) and constant load (port 1).
// Latency: combinational grant, rvalid/rdata exactly one cycle after the grant.
// Backpressure: requesters hold req until granted; responses cannot be stalled.
// Optional macro ROM_ARB_HOLD_EN: per-port hold registers keep the last returned word.
module rom_arbiter #(
  parameter int AW       = 10,
  parameter int DW       = 32,
  parameter int ARB_MODE = 0,
  parameter int MAX_WAIT = 4
) (
  input logic        clk,
  input logic        rst,
  rom_arbiter_if.slave bus
);

  // Wide enough to hold MAX_WAIT; a single bit when the guard is disabled.
  localparam int WW = (MAX_WAIT < 1) ? 1 : $clog2(MAX_WAIT + 1);

  logic          gnt0;
  logic          gnt1;
  logic          any_gnt;
  logic          force1;
  logic [AW-1:0] last_addr;
  logic [AW-1:0] rom_addr;
  logic [WW-1:0] wait1;
  logic          rr_last;
  logic          tag_v;
  logic          tag_port;
  logic          rvalid0;
  logic          rvalid1;
  logic [DW-1:0] rom_word;

  assign rom_word = bus.rom_dout;
  assign any_gnt  = gnt0 | gnt1;

  // Port 1 is forced through once it has been blocked MAX_WAIT cycles in a row.
  assign force1 = (MAX_WAIT != 0) && (wait1 == WW'(MAX_WAIT));

  // Pick at most one requester per cycle; nothing is granted while in reset.
  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (!rst) begin
      if (bus.req0 && !bus.req1) begin
        gnt0 = 1'b1;
      end else if (!bus.req0 && bus.req1) begin
        gnt1 = 1'b1;
      end else if (bus.req0 && bus.req1) begin
        if (ARB_MODE == 0) begin
          if (force1) gnt1 = 1'b1;
          else        gnt0 = 1'b1;
        end else begin
          // Whichever port was not served last goes next.
          if (rr_last) gnt0 = 1'b1;
          else         gnt1 = 1'b1;
        end
      end
    end
  end

  // Steer the granted address to the ROM; park on the last address when idle.
  always_comb begin
    rom_addr = last_addr;
    if (gnt0)      rom_addr = bus.addr0;
    else if (gnt1) rom_addr = bus.addr1;
  end

  // Arbitration state: parked address, port 1 starvation count, round-robin owner.
  always_ff @(posedge clk) begin
    if (rst) begin
      last_addr <= '0;
      wait1     <= '0;
      rr_last   <= 1'b1;
    end else begin
      if (any_gnt) begin
        last_addr <= rom_addr;
        rr_last   <= gnt1;
      end
      if (bus.req1 && !gnt1) begin
        if (wait1 != WW'(MAX_WAIT)) wait1 <= wait1 + WW'(1);
      end else begin
        wait1 <= '0;
      end
    end
  end

  // Tag the in-flight read so the returning ROM word goes to its owner.
  always_ff @(posedge clk) begin
    if (rst) begin
      tag_v    <= 1'b0;
      tag_port <= 1'b0;
    end else begin
      tag_v    <= any_gnt;
      tag_port <= gnt1;
    end
  end

  assign rvalid0 = tag_v & ~tag_port;
  assign rvalid1 = tag_v &  tag_port;

`ifdef ROM_ARB_HOLD_EN
  logic [DW-1:0] hold0;
  logic [DW-1:0] hold1;

  // Capture each port's response so it stays visible while the other port reads.
  always_ff @(posedge clk) begin
    if (rst) begin
      hold0 <= '0;
      hold1 <= '0;
    end else begin
      if (rvalid0) hold0 <= rom_word;
      if (rvalid1) hold1 <= rom_word;
    end
  end

  assign bus.rdata0 = rvalid0 ? rom_word : hold0;
  assign bus.rdata1 = rvalid1 ? rom_word : hold1;
`else
  assign bus.rdata0 = rom_word;
  assign bus.rdata1 = rom_word;
`endif

  assign bus.gnt0     = gnt0;
  assign bus.gnt1     = gnt1;
  assign bus.rvalid0  = rvalid0;
  assign bus.rvalid1  = rvalid1;
  assign bus.rom_addr = rom_addr;

endmodule

// File: tb/tb_rom_arbiter.sv
// Directed bench for rom_arbiter: one fixed-priority instance and one round-robin instance,
// each attached to a ROM model whose word i is 32'hA500_0000 | i.
module tb_rom_arbiter;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_run  = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  rom_arbiter_if #(.AW(10), .DW(32)) b0 ();
  rom_arbiter_if #(.AW(10), .DW(32)) b1 ();

  rom_arbiter #(.AW(10), .DW(32), .ARB_MODE(0), .MAX_WAIT(4)) dut0 (
    .clk (clk),
    .rst (rst),
    .bus (b0.slave)
  );

  rom_arbiter #(.AW(10), .DW(32), .ARB_MODE(1), .MAX_WAIT(4)) dut1 (
    .clk (clk),
    .rst (rst),
    .bus (b1.slave)
  );

  // Synchronous-read ROM models.
  always @(posedge clk) begin
    b0.rom_dout <= 32'hA500_0000 | {22'd0, b0.rom_addr};
    b1.rom_dout <= 32'hA500_0000 | {22'd0, b1.rom_addr};
  end

  // Advance to just after the next rising edge.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    b0.req0 = 1'b1; b0.addr0 = 10'h005;
    b1.req0 = 1'b1; b1.addr0 = 10'h005;
    cyc();
    cyc();
    #1;
    n_run++; if (b0.gnt0 !== 1'b0) begin n_fail++; $display("FAIL reset_gnt0 got=%b exp=0", b0.gnt0); end
    n_run++; if (b1.gnt0 !== 1'b0) begin n_fail++; $display("FAIL reset_gnt0_rr got=%b exp=0", b1.gnt0); end
    n_run++; if ({b0.rvalid0, b0.rvalid1} !== 2'b00) begin n_fail++; $display("FAIL reset_rvalid got=%b exp=00", {b0.rvalid0, b0.rvalid1}); end
    n_run++; if (b0.rom_addr !== 10'h000) begin n_fail++; $display("FAIL reset_rom_addr got=%h exp=000", b0.rom_addr); end
    b0.req0 = 1'b0;
    b1.req0 = 1'b0;
    rst = 1'b0;
    cyc();
  endtask

  task automatic test_single();
    b0.req0 = 1'b1; b0.addr0 = 10'h005;
    #1;
    n_run++; if ({b0.gnt0, b0.gnt1} !== 2'b10) begin n_fail++; $display("FAIL single_gnt got=%b exp=10", {b0.gnt0, b0.gnt1}); end
    n_run++; if (b0.rom_addr !== 10'h005) begin n_fail++; $display("FAIL single_rom_addr got=%h exp=005", b0.rom_addr); end
    cyc();
    b0.req0 = 1'b0;
    #1;
    n_run++; if ({b0.rvalid0, b0.rvalid1} !== 2'b10) begin n_fail++; $display("FAIL single_rvalid got=%b exp=10", {b0.rvalid0, b0.rvalid1}); end
    n_run++; if (b0.rdata0 !== 32'hA500_0005) begin n_fail++; $display("FAIL single_rdata0 got=%h exp=a5000005", b0.rdata0); end
    cyc();
    #1;
    n_run++; if (b0.rvalid0 !== 1'b0) begin n_fail++; $display("FAIL single_pulse got=%b exp=0", b0.rvalid0); end
  endtask

  task automatic test_fixed_priority();
    logic prev_g0;
    logic prev_g1;
    logic exp_g1;
    prev_g0 = 1'b0;
    prev_g1 = 1'b0;
    b0.req0 = 1'b1; b0.addr0 = 10'd3;
    b0.req1 = 1'b1; b0.addr1 = 10'd9;
    for (int i = 0; i < 10; i++) begin
      #1;
      exp_g1 = (i == 4) || (i == 9);
      n_run++; if ({b0.gnt0, b0.gnt1} !== {~exp_g1, exp_g1}) begin n_fail++; $display("FAIL prio_gnt cyc=%0d got=%b exp=%b", i, {b0.gnt0, b0.gnt1}, {~exp_g1, exp_g1}); end
      n_run++; if ({b0.rvalid0, b0.rvalid1} !== {prev_g0, prev_g1}) begin n_fail++; $display("FAIL prio_rvalid cyc=%0d got=%b exp=%b", i, {b0.rvalid0, b0.rvalid1}, {prev_g0, prev_g1}); end
      if (prev_g1) begin
        n_run++; if (b0.rdata1 !== 32'hA500_0009) begin n_fail++; $display("FAIL prio_rdata1 cyc=%0d got=%h exp=a5000009", i, b0.rdata1); end
      end
      if (prev_g0) begin
        n_run++; if (b0.rdata0 !== 32'hA500_0003) begin n_fail++; $display("FAIL prio_rdata0 cyc=%0d got=%h exp=a5000003", i, b0.rdata0); end
      end
      if (i == 5) begin
        n_run++; if (dut0.wait1 !== 3'd0) begin n_fail++; $display("FAIL prio_wait1_clear got=%0d exp=0", dut0.wait1); end
      end
      prev_g0 = ~exp_g1;
      prev_g1 = exp_g1;
      cyc();
    end
    b0.req0 = 1'b0;
    b0.req1 = 1'b0;
    cyc();
  endtask

  task automatic test_round_robin();
    logic exp_g0;
    logic prev_g0;
    logic prev_g1;
    rst = 1'b1;
    cyc();
    b1.req0 = 1'b1; b1.addr0 = 10'd3;
    b1.req1 = 1'b1; b1.addr1 = 10'd9;
    rst = 1'b0;
    prev_g0 = 1'b0;
    prev_g1 = 1'b0;
    for (int i = 0; i < 6; i++) begin
      #1;
      exp_g0 = (i % 2 == 0);
      n_run++; if ({b1.gnt0, b1.gnt1} !== {exp_g0, ~exp_g0}) begin n_fail++; $display("FAIL rr_gnt cyc=%0d got=%b exp=%b", i, {b1.gnt0, b1.gnt1}, {exp_g0, ~exp_g0}); end
      n_run++; if ({b1.rvalid0, b1.rvalid1} !== {prev_g0, prev_g1}) begin n_fail++; $display("FAIL rr_rvalid cyc=%0d got=%b exp=%b", i, {b1.rvalid0, b1.rvalid1}, {prev_g0, prev_g1}); end
      if (prev_g0) begin
        n_run++; if (b1.rdata0 !== 32'hA500_0003) begin n_fail++; $display("FAIL rr_rdata0 cyc=%0d got=%h exp=a5000003", i, b1.rdata0); end
      end
      if (prev_g1) begin
        n_run++; if (b1.rdata1 !== 32'hA500_0009) begin n_fail++; $display("FAIL rr_rdata1 cyc=%0d got=%h exp=a5000009", i, b1.rdata1); end
      end
      prev_g0 = exp_g0;
      prev_g1 = ~exp_g0;
      cyc();
    end
    b1.req0 = 1'b0;
    b1.req1 = 1'b0;
    cyc();
  endtask

  task automatic test_reset_mid();
    rst = 1'b1;
    b0.req0 = 1'b1; b0.addr0 = 10'd4;
    #1;
    n_run++; if (b0.gnt0 !== 1'b0) begin n_fail++; $display("FAIL midrst_gnt0 got=%b exp=0", b0.gnt0); end
    cyc();
    rst = 1'b0;
    b0.req0 = 1'b0;
    #1;
    n_run++; if (b0.rvalid0 !== 1'b0) begin n_fail++; $display("FAIL midrst_rvalid0 got=%b exp=0", b0.rvalid0); end
    b0.req0 = 1'b1; b0.addr0 = 10'd7;
    #1;
    n_run++; if (b0.gnt0 !== 1'b1) begin n_fail++; $display("FAIL midrst_first_gnt got=%b exp=1", b0.gnt0); end
    cyc();
    b0.req0 = 1'b0;
    #1;
    n_run++; if ({b0.rvalid0, b0.rdata0} !== {1'b1, 32'hA500_0007}) begin n_fail++; $display("FAIL midrst_resp got=%b/%h exp=1/a5000007", b0.rvalid0, b0.rdata0); end
    cyc();
  endtask

  task automatic test_idle_addr();
    b0.req0 = 1'b1; b0.addr0 = 10'd12;
    cyc();
    b0.req0 = 1'b0;
    b0.addr0 = 10'd0;
    for (int i = 0; i < 3; i++) begin
      #1;
      n_run++; if (b0.rom_addr !== 10'd12) begin n_fail++; $display("FAIL idle_rom_addr cyc=%0d got=%h exp=00c", i, b0.rom_addr); end
      cyc();
    end
    rst = 1'b1;
    cyc();
    #1;
    n_run++; if (b0.rom_addr !== 10'd0) begin n_fail++; $display("FAIL idle_after_reset got=%h exp=000", b0.rom_addr); end
    rst = 1'b0;
    cyc();
  endtask

  task automatic test_hold();
    logic [31:0] exp_r0;
    b0.req0 = 1'b1; b0.addr0 = 10'd2;
    cyc();
    b0.req0 = 1'b0;
    b0.req1 = 1'b1; b0.addr1 = 10'd8;
    #1;
    n_run++; if ({b0.rvalid0, b0.rdata0} !== {1'b1, 32'hA500_0002}) begin n_fail++; $display("FAIL hold_resp0 got=%b/%h exp=1/a5000002", b0.rvalid0, b0.rdata0); end
    n_run++; if (b0.gnt1 !== 1'b1) begin n_fail++; $display("FAIL hold_gnt1 got=%b exp=1", b0.gnt1); end
    cyc();
    b0.req1 = 1'b0;
`ifdef ROM_ARB_HOLD_EN
    exp_r0 = 32'hA500_0002;
`else
    exp_r0 = 32'hA500_0008;
`endif
    for (int i = 0; i < 2; i++) begin
      #1;
      n_run++; if (b0.rdata1 !== 32'hA500_0008) begin n_fail++; $display("FAIL hold_rdata1 cyc=%0d got=%h exp=a5000008", i, b0.rdata1); end
      n_run++; if (b0.rdata0 !== exp_r0) begin n_fail++; $display("FAIL hold_rdata0 cyc=%0d got=%h exp=%h", i, b0.rdata0, exp_r0); end
      cyc();
    end
  endtask

  initial begin
    b0.req0 = 1'b0; b0.addr0 = '0; b0.req1 = 1'b0; b0.addr1 = '0;
    b1.req0 = 1'b0; b1.addr0 = '0; b1.req1 = 1'b0; b1.addr1 = '0;
    #2;
    test_reset();
    test_single();
    test_fixed_priority();
    test_round_robin();
    test_reset_mid();
    test_idle_addr();
    test_hold();
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
